cellrv32_npu_mmu_sequencer: RTL and testbench

Next-generation matrix-multiply controller for the NPU.
- Accepts matrix-multiply instructions through a valid/ready queue and issues one systolic row per cycle.
- Drives unified-buffer reads, the SDS/MMU enable and weight activation, and the accumulator write port through latency-parametrised delay lines.
- Chains queued instructions back-to-back with no bubble and supports a flush.
- Sits between the NPU instruction dispatcher and the buffer/SDS/MMU/accumulator datapath.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/cellrv32_npu_delay_line.sv | 36 +++
 rtl/cellrv32_npu_mmu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cellrv32_npu_mmu_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared NPU instruction format, address widths and MMU sequencer state encoding
package tpu_pkg;
    localparam int BUFFER_ADDRESS_WIDTH      = 16;
    localparam int ACCUMULATOR_ADDRESS_WIDTH = 16;
    localparam int LENGTH_WIDTH              = 16;

    typedef struct packed {
        logic [1:0]                           opcode;
        logic [LENGTH_WIDTH-1:0]              calc_len;
        logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_addr;
        logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
    } instruction_t;

    typedef enum logic {IDLE, RUN} mmu_seq_state_t;
endpackage

// File: rtl/cellrv32_npu_delay_line.sv
// cellrv32_npu_delay_line: enable-gated shift register carrying a valid bit and payload,
// with a flag that reports whether any stage still holds a valid entry
module cellrv32_npu_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             any_o
);
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld <= '0;
            dat <= '0;
        end else if (en_i) begin
            vld[0] <= valid_i;
            dat[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign valid_o = vld[DEPTH-1];
    assign data_o  = dat[DEPTH-1];
    assign any_o   = |vld;
endmodule

// File: rtl/cellrv32_npu_mmu_sequencer.sv
// cellrv32_npu_mmu_sequencer: queued matrix-multiply issue FSM driving buffer, SDS/MMU and accumulator.
// Optional NPU_MMU_SEQ_PERF_CNT_EN adds saturating issued-row and stall-cycle counters.
module cellrv32_npu_mmu_sequencer
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH     = 14,
    parameter int INST_QUEUE_DEPTH = 2,
    parameter int SDS_LATENCY      = 3,
    parameter int ACC_LATENCY      = MATRIX_WIDTH + 2
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 enable_i,
    input  logic                                 flush_i,
    input  instruction_t                         inst_i,
    input  logic                                 inst_valid_i,
    output logic                                 inst_ready_o,
`ifdef NPU_MMU_SEQ_PERF_CNT_EN
    input  logic                                 perf_clr_i,
    output logic [31:0]                          perf_rows_o,
    output logic [31:0]                          perf_stall_o,
`endif
    output logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_sds_addr_o,
    output logic                                 buff_read_en_o,
    output logic                                 mmu_sds_en_o,
    output logic                                 mmu_signed_o,
    output logic                                 act_wei_o,
    output logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr_o,
    output logic                                 acc_o,
    output logic                                 acc_en_o,
    output logic                                 busy_o,
    output logic                                 resource_busy_o
);
    localparam int PW = INST_QUEUE_DEPTH > 1 ? $clog2(INST_QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(INST_QUEUE_DEPTH + 1);
    localparam int WW = MATRIX_WIDTH > 1 ? $clog2(MATRIX_WIDTH) : 1;
    localparam int AW = ACCUMULATOR_ADDRESS_WIDTH;

    instruction_t   q_mem [INST_QUEUE_DEPTH];
    instruction_t   head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  q_cnt;
    logic           q_empty, q_full, push, pop, load, issue, last_row;
    mmu_seq_state_t state_q, state_d;
    logic [LENGTH_WIDTH-1:0]         row_cnt, len_q;
    logic [WW-1:0]                   wcnt;
    logic [BUFFER_ADDRESS_WIDTH-1:0] buf_addr;
    logic [AW-1:0]                   acc_addr, iss_acc_addr, sds_acc_addr;
    logic accum, sgn, iss_sgn, iss_act, iss_accum, sds_accum, sds_any, acc_any;

    assign q_empty      = q_cnt == '0;
    assign q_full       = q_cnt == CW'(INST_QUEUE_DEPTH);
    assign inst_ready_o = !q_full;
    assign push         = inst_valid_i && !q_full && !flush_i;
    assign head         = q_mem[rd_ptr];

    always_ff @(posedge clk_i)
        if (push) q_mem[wr_ptr] <= inst_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(INST_QUEUE_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PW'(INST_QUEUE_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            q_cnt <= q_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) state_q <= IDLE;
        else state_q <= state_d;

    always_comb
        state_d = flush_i ? IDLE : !enable_i ? state_q : load ? RUN :
                  (state_q == RUN && !last_row) ? RUN : IDLE;

    // A pop on the last row reloads in the same cycle, so chained instructions run bubble-free
    always_comb begin
        last_row = row_cnt == len_q - 1'b1;
        issue    = enable_i && state_q == RUN;
        pop      = enable_i && !flush_i && !q_empty && (state_q == IDLE || last_row);
        load     = pop && head.calc_len != '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            row_cnt  <= '0;
            len_q    <= '0;
            wcnt     <= '0;
            buf_addr <= '0;
            acc_addr <= '0;
            accum    <= 1'b0;
            sgn      <= 1'b0;
        end else if (load) begin
            row_cnt  <= '0;
            len_q    <= head.calc_len;
            wcnt     <= '0;
            buf_addr <= head.buff_addr;
            acc_addr <= head.acc_addr;
            accum    <= head.opcode[1];
            sgn      <= head.opcode[0];
        end else if (issue) begin
            row_cnt  <= row_cnt + 1'b1;
            wcnt     <= wcnt == WW'(MATRIX_WIDTH - 1) ? '0 : wcnt + 1'b1;
            buf_addr <= buf_addr + 1'b1;
            acc_addr <= acc_addr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            buff_read_en_o  <= 1'b0;
            buff_sds_addr_o <= '0;
            iss_sgn         <= 1'b0;
            iss_act         <= 1'b0;
            iss_accum       <= 1'b0;
            iss_acc_addr    <= '0;
        end else if (enable_i) begin
            buff_read_en_o  <= issue;
            buff_sds_addr_o <= issue ? buf_addr : '0;
            iss_sgn         <= issue && sgn;
            iss_act         <= issue && wcnt == '0;
            iss_accum       <= issue && accum;
            iss_acc_addr    <= issue ? acc_addr : '0;
        end
    end

    cellrv32_npu_delay_line #(.WIDTH(AW + 3), .DEPTH(SDS_LATENCY)) u_sds_dly (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (enable_i),
        .valid_i (buff_read_en_o),
        .data_i  ({iss_sgn, iss_act, iss_accum, iss_acc_addr}),
        .valid_o (mmu_sds_en_o),
        .data_o  ({mmu_signed_o, act_wei_o, sds_accum, sds_acc_addr}),
        .any_o   (sds_any)
    );

    cellrv32_npu_delay_line #(.WIDTH(AW + 1), .DEPTH(ACC_LATENCY)) u_acc_dly (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (enable_i),
        .valid_i (mmu_sds_en_o),
        .data_i  ({sds_accum, sds_acc_addr}),
        .valid_o (acc_en_o),
        .data_o  ({acc_o, acc_addr_o}),
        .any_o   (acc_any)
    );

    assign busy_o          = state_q == RUN || !q_empty;
    assign resource_busy_o = busy_o || buff_read_en_o || sds_any || acc_any;

`ifdef NPU_MMU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_rows_o  <= '0;
            perf_stall_o <= '0;
        end else if (perf_clr_i) begin
            perf_rows_o  <= '0;
            perf_stall_o <= '0;
        end else begin
            if (issue && perf_rows_o != '1) perf_rows_o <= perf_rows_o + 1'b1;
            if (busy_o && !enable_i && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cellrv32_npu_mmu_sequencer.sv
// tb_cellrv32_npu_mmu_sequencer: directed self-checking bench with hand-computed timing and addresses
module tb_cellrv32_npu_mmu_sequencer;
    import tpu_pkg::*;

    logic clk_i = 1'b0, rstn_i, enable_i, flush_i, inst_valid_i, inst_ready_o;
    instruction_t inst_i;
    logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_sds_addr_o;
    logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr_o;
    logic buff_read_en_o, mmu_sds_en_o, mmu_signed_o, act_wei_o, acc_o, acc_en_o, busy_o, resource_busy_o;
`ifdef NPU_MMU_SEQ_PERF_CNT_EN
    logic        perf_clr_i = 1'b0;
    logic [31:0] perf_rows_o, perf_stall_o;
`endif

    int errors = 0, checks = 0, cyc = 0, t0, waited;
    logic en_q = 1'b0;
    int buf_cyc[$], buf_adr[$], mmu_cyc[$], act_cyc[$], acc_cyc[$], acc_adr[$], acc_flag[$];

    always #5 clk_i = ~clk_i;

    cellrv32_npu_mmu_sequencer dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .enable_i        (enable_i),
        .flush_i         (flush_i),
        .inst_i          (inst_i),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
`ifdef NPU_MMU_SEQ_PERF_CNT_EN
        .perf_clr_i      (perf_clr_i),
        .perf_rows_o     (perf_rows_o),
        .perf_stall_o    (perf_stall_o),
`endif
        .buff_sds_addr_o (buff_sds_addr_o),
        .buff_read_en_o  (buff_read_en_o),
        .mmu_sds_en_o    (mmu_sds_en_o),
        .mmu_signed_o    (mmu_signed_o),
        .act_wei_o       (act_wei_o),
        .acc_addr_o      (acc_addr_o),
        .acc_o           (acc_o),
        .acc_en_o        (acc_en_o),
        .busy_o          (busy_o),
        .resource_busy_o (resource_busy_o)
    );

    always @(posedge clk_i) begin
        cyc  <= cyc + 1;
        en_q <= enable_i;
    end

    // Log output events once per enabled edge so stalled (held) outputs are not double-counted
    always @(negedge clk_i) if (en_q && rstn_i) begin
        if (buff_read_en_o) begin buf_cyc.push_back(cyc); buf_adr.push_back(int'(buff_sds_addr_o)); end
        if (mmu_sds_en_o) mmu_cyc.push_back(cyc);
        if (act_wei_o) act_cyc.push_back(cyc);
        if (acc_en_o) begin
            acc_cyc.push_back(cyc);
            acc_adr.push_back(int'(acc_addr_o));
            acc_flag.push_back(int'(acc_o));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    function automatic instruction_t mk(input logic [1:0] op, input int len, input int ba, input int aa);
        instruction_t r;
        r.opcode    = op;
        r.calc_len  = len[LENGTH_WIDTH-1:0];
        r.buff_addr = ba[BUFFER_ADDRESS_WIDTH-1:0];
        r.acc_addr  = aa[ACCUMULATOR_ADDRESS_WIDTH-1:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        buf_cyc.delete(); buf_adr.delete(); mmu_cyc.delete(); act_cyc.delete();
        acc_cyc.delete(); acc_adr.delete(); acc_flag.delete();
    endtask

    task automatic push_one(input instruction_t ins);
        clear_logs();
        inst_i = ins;
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0; enable_i = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; inst_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        check("rst_ready", inst_ready_o, 1);
        check("rst_buf_en", buff_read_en_o, 0);
        check("rst_buf_addr", buff_sds_addr_o, 0);
        check("rst_mmu_en", mmu_sds_en_o, 0);
        check("rst_signed", mmu_signed_o, 0);
        check("rst_act", act_wei_o, 0);
        check("rst_acc_en", acc_en_o, 0);
        check("rst_acc", acc_o, 0);
        check("rst_acc_addr", acc_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rbusy", resource_busy_o, 0);

        // single instruction: cycle-accurate check of every output
        push_one(mk(2'b11, 3, 'h10, 'h20));
        for (int t = 1; t <= 25; t++) begin
            logic be, me, ae;
            tick();
            be = t >= 2 && t <= 4;
            me = t >= 5 && t <= 7;
            ae = t >= 21 && t <= 23;
            check($sformatf("s_buf_en@%0d", t), buff_read_en_o, be);
            if (be) check($sformatf("s_buf_addr@%0d", t), buff_sds_addr_o, 'h10 + t - 2);
            check($sformatf("s_mmu_en@%0d", t), mmu_sds_en_o, me);
            check($sformatf("s_signed@%0d", t), mmu_signed_o, me);
            check($sformatf("s_act@%0d", t), act_wei_o, t == 5);
            check($sformatf("s_acc_en@%0d", t), acc_en_o, ae);
            check($sformatf("s_acc@%0d", t), acc_o, ae);
            if (ae) check($sformatf("s_acc_addr@%0d", t), acc_addr_o, 'h20 + t - 21);
            check($sformatf("s_busy@%0d", t), busy_o, t <= 3);
            check($sformatf("s_rbusy@%0d", t), resource_busy_o, t <= 23);
        end

        // back-to-back chaining of two queued instructions
        push_one(mk(2'b10, 2, 'h00, 'h00));
        inst_i = mk(2'b00, 3, 'h80, 'h40);
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        repeat (40) tick();
        check("b2b_buf_cnt", buf_cyc.size(), 5);
        check("b2b_buf_first", qat(buf_cyc, 0) - t0, 2);
        check("b2b_buf_last", qat(buf_cyc, 4) - t0, 6);
        check("b2b_buf_addr2", qat(buf_adr, 2), 'h80);
        check("b2b_act_cnt", act_cyc.size(), 2);
        check("b2b_act0", qat(act_cyc, 0) - t0, 5);
        check("b2b_act1", qat(act_cyc, 1) - t0, 7);
        check("b2b_acc_cnt", acc_cyc.size(), 5);
        check("b2b_acc_flag0", qat(acc_flag, 0), 1);
        check("b2b_acc_flag2", qat(acc_flag, 2), 0);
        check("b2b_acc_addr2", qat(acc_adr, 2), 'h40);
        check("b2b_rbusy_end", resource_busy_o, 0);

        // weight activation period
        push_one(mk(2'b00, 30, 'h100, 'h200));
        repeat (60) tick();
        check("wp_mmu_cnt", mmu_cyc.size(), 30);
        check("wp_act_cnt", act_cyc.size(), 3);
        check("wp_act0", qat(act_cyc, 0) - t0, 5);
        check("wp_act1", qat(act_cyc, 1) - t0, 19);
        check("wp_act2", qat(act_cyc, 2) - t0, 33);
        check("wp_last_acc", qat(acc_cyc, 29) - t0, 50);

        // queue full while a long instruction runs
        push_one(mk(2'b00, 20, 'h300, 'h0));
        tick();
        inst_i = mk(2'b00, 1, 'h40, 'h0);
        inst_valid_i = 1'b1;
        tick();
        check("qf_ready_one", inst_ready_o, 1);
        inst_i = mk(2'b00, 1, 'h50, 'h0);
        tick();
        check("qf_ready_full", inst_ready_o, 0);
        inst_i = mk(2'b00, 1, 'h60, 'h0);
        waited = 0;
        while (!inst_ready_o && waited < 100) begin
            tick();
            waited++;
        end
        check("qf_wait_cycles", waited, 18);
        tick();
        inst_valid_i = 1'b0;
        repeat (30) tick();
        check("qf_buf_cnt", buf_cyc.size(), 23);
        check("qf_addr_q0", qat(buf_adr, 20), 'h40);
        check("qf_addr_q1", qat(buf_adr, 21), 'h50);
        check("qf_addr_q2", qat(buf_adr, 22), 'h60);

        // stall mid-run holds outputs, rows resume intact
        push_one(mk(2'b01, 6, 'h30, 'h70));
        repeat (5) tick();
        enable_i = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("st_buf_en@%0d", s), buff_read_en_o, 1);
            check($sformatf("st_buf_addr@%0d", s), buff_sds_addr_o, 'h33);
            check($sformatf("st_mmu_en@%0d", s), mmu_sds_en_o, 1);
            check($sformatf("st_act@%0d", s), act_wei_o, 1);
            check($sformatf("st_signed@%0d", s), mmu_signed_o, 1);
        end
        enable_i = 1'b1;
        repeat (40) tick();
        check("st_buf_cnt", buf_cyc.size(), 6);
        check("st_buf_r4", qat(buf_cyc, 4) - t0, 10);
        check("st_buf_a5", qat(buf_adr, 5), 'h35);
        check("st_act_cnt", act_cyc.size(), 1);
        check("st_acc_cnt", acc_cyc.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("st_acc_addr%0d", i), qat(acc_adr, i), 'h70 + i);
        check("st_acc_last", qat(acc_cyc, 5) - t0, 30);
        check("st_acc_flag", qat(acc_flag, 0), 0);

        // flush during row 1 with a queued instruction and a simultaneous push
        push_one(mk(2'b00, 10, 'h90, 'hA0));
        tick();
        inst_i = mk(2'b00, 5, 'hC0, 'hC0);
        inst_valid_i = 1'b1;
        tick();
        inst_i = mk(2'b00, 5, 'hD0, 'hD0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        check("fl_busy", busy_o, 0);
        check("fl_ready", inst_ready_o, 1);
        repeat (40) tick();
        check("fl_buf_cnt", buf_cyc.size(), 2);
        check("fl_buf_a1", qat(buf_adr, 1), 'h91);
        check("fl_acc_cnt", acc_cyc.size(), 2);
        check("fl_acc_a0", qat(acc_adr, 0), 'hA0);
        check("fl_acc_a1", qat(acc_adr, 1), 'hA1);
        check("fl_rbusy_end", resource_busy_o, 0);

        // calc_len=0 is discarded without output
        push_one(mk(2'b11, 0, 'h10, 'h10));
        check("z_busy_queued", busy_o, 1);
        tick();
        check("z_busy_after", busy_o, 0);
        repeat (25) tick();
        check("z_buf_cnt", buf_cyc.size(), 0);
        check("z_mmu_cnt", mmu_cyc.size(), 0);
        check("z_acc_cnt", acc_cyc.size(), 0);

        // address wrap at maximum
        push_one(mk(2'b00, 2, 'hFFFF, 'hFFFF));
        repeat (30) tick();
        check("w_buf_a0", qat(buf_adr, 0), 'hFFFF);
        check("w_buf_a1", qat(buf_adr, 1), 'h0);
        check("w_acc_cnt", acc_cyc.size(), 2);
        check("w_acc_a0", qat(acc_adr, 0), 'hFFFF);
        check("w_acc_a1", qat(acc_adr, 1), 'h0);
        check("w_rbusy_end", resource_busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
